// File: rtl/spi_crypto_frame_ctrl_if.sv
// Bundle of the serial frame pins and the crypto-core handoff signals of spi_crypto_frame_ctrl.
// The master side is the SPI host plus the attached core; the slave side is the controller.
interface spi_crypto_frame_ctrl_if #(
    parameter int nk = 8,
    parameter int nb = 4
);
    logic              cs;
    logic              mosi;
    logic              miso;
    logic              core_mode;
    logic [32*nk-1:0]  core_key;
    logic [32*nb-1:0]  core_msg;
    logic [32*nb-1:0]  core_out;
    logic              data_done;
    logic              busy;
    logic              key_valid;
    logic              err;

    modport slave (
        input  cs, mosi, core_out,
        output miso, core_mode, core_key, core_msg, data_done, busy, key_valid, err
    );

    modport master (
        output cs, mosi, core_out,
        input  miso, core_mode, core_key, core_msg, data_done, busy, key_valid, err
    );
endinterface

// File: rtl/spi_crypto_frame_ctrl.sv
// Serial frame controller: takes header, optional key and a block over a clk-synchronous
// SPI-like link, hands them to a crypto core, then shifts the core result back out on miso.
//
// state | meaning
// IDLE  | waiting for cs low; the first low edge carries header bit 7 (mode)
// HDR   | receiving header bits 6..0 (bit 6 = key_load)
// KEY   | shifting 32*nk key bits into staging
// MSG   | shifting 32*nb block bits
// WAIT  | counting core_lat cycles for the core
// OUT   | result on miso, MSB first
// DRAIN | frame finished or rejected; miso held low until cs rises
module spi_crypto_frame_ctrl #(
    parameter int nk       = 8,
    parameter int nb       = 4,
    parameter int core_lat = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_crypto_frame_ctrl_if.slave  bus
);
    localparam int kw   = 32 * nk;
    localparam int mw   = 32 * nb;
    localparam int cmax = (kw > mw) ? kw : mw;
    localparam int cw   = $clog2(cmax + 1);

    localparam logic [cw-1:0] one_c    = cw'(1);
    localparam logic [cw-1:0] hdr_ld   = cw'(7);
    localparam logic [cw-1:0] key_ld   = cw'(kw);
    localparam logic [cw-1:0] msg_ld   = cw'(mw);
    localparam logic [cw-1:0] lat_ld   = cw'(core_lat);

    typedef enum logic [2:0] {IDLE, HDR, KEY, MSG, WAIT, OUT, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [cw-1:0]   cnt;
    logic            hdr_mode;
    logic            hdr_load;
    logic [kw-2:0]   key_sr;
    logic [mw-2:0]   msg_sr;
    logic [mw-1:0]   out_sr;
    logic [kw-1:0]   core_key_q;
    logic [mw-1:0]   core_msg_q;
    logic            core_mode_q;
    logic            key_valid_q;
    logic            data_done_q;
    logic            err_q;
    logic            last_bit;
    logic            wait_done;
    logic [cw-1:0]   cnt_dec;

    assign last_bit  = (cnt == one_c);
    assign wait_done = (cnt == '0);
    // Saturating decrement: the counter never wraps below zero.
    assign cnt_dec   = wait_done ? '0 : cnt - one_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.cs) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = HDR;
                HDR:   if (last_bit) begin
                           if (hdr_load)         state_nxt = KEY;
                           else if (key_valid_q) state_nxt = MSG;
                           else                  state_nxt = DRAIN;
                       end
                KEY:   if (last_bit)  state_nxt = MSG;
                MSG:   if (last_bit)  state_nxt = WAIT;
                WAIT:  if (wait_done) state_nxt = OUT;
                OUT:   if (last_bit)  state_nxt = DRAIN;
                DRAIN: state_nxt = DRAIN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            hdr_mode    <= 1'b0;
            hdr_load    <= 1'b0;
            key_sr      <= '0;
            msg_sr      <= '0;
            out_sr      <= '0;
            core_key_q  <= '0;
            core_msg_q  <= '0;
            core_mode_q <= 1'b0;
            key_valid_q <= 1'b0;
            data_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            data_done_q <= 1'b0;
            err_q       <= 1'b0;
            if (bus.cs) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        hdr_mode <= bus.mosi;
                        cnt      <= hdr_ld;
                    end
                    HDR: begin
                        if (cnt == hdr_ld) hdr_load <= bus.mosi;
                        if (last_bit) begin
                            if (hdr_load) begin
                                cnt <= key_ld;
                            end else if (key_valid_q) begin
                                cnt <= msg_ld;
                            end else begin
                                err_q <= 1'b1;
                                cnt   <= '0;
                            end
                        end else begin
                            cnt <= cnt_dec;
                        end
                    end
                    KEY: begin
                        key_sr <= {key_sr[kw-3:0], bus.mosi};
                        // The key is only committed on the final bit so an aborted load leaves the old key intact.
                        if (last_bit) begin
                            core_key_q  <= {key_sr, bus.mosi};
                            key_valid_q <= 1'b1;
                            cnt         <= msg_ld;
                        end else begin
                            cnt <= cnt_dec;
                        end
                    end
                    MSG: begin
                        msg_sr <= {msg_sr[mw-3:0], bus.mosi};
                        if (last_bit) begin
                            core_msg_q  <= {msg_sr, bus.mosi};
                            core_mode_q <= hdr_mode;
                            cnt         <= lat_ld;
                        end else begin
                            cnt <= cnt_dec;
                        end
                    end
                    WAIT: begin
                        if (wait_done) begin
                            out_sr      <= bus.core_out;
                            data_done_q <= 1'b1;
                            cnt         <= msg_ld;
                        end else begin
                            cnt <= cnt_dec;
                        end
                    end
                    OUT: begin
                        if (last_bit) begin
                            cnt <= '0;
                        end else begin
                            out_sr <= {out_sr[mw-2:0], 1'b0};
                            cnt    <= cnt_dec;
                        end
                    end
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    assign bus.miso      = (state == OUT) ? out_sr[mw-1] : 1'b0;
    assign bus.busy      = (state != IDLE);
    assign bus.core_key  = core_key_q;
    assign bus.core_msg  = core_msg_q;
    assign bus.core_mode = core_mode_q;
    assign bus.key_valid = key_valid_q;
    assign bus.data_done = data_done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_spi_crypto_frame_ctrl.sv
// Bench for spi_crypto_frame_ctrl: two instances (core_lat 0 and 3) share one serial stimulus
// and are compared against a frame-level model of key retention, result timing and miso.
module tb_spi_crypto_frame_ctrl;
    localparam int NK   = 4;
    localparam int NB   = 4;
    localparam int LAT1 = 3;

    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst;
    logic cs;
    logic mosi;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [127:0] mk;
    logic         mkv;

    always #5 clk = ~clk;

    spi_crypto_frame_ctrl_if #(.nk(NK), .nb(NB)) bus0 ();
    spi_crypto_frame_ctrl_if #(.nk(NK), .nb(NB)) bus3 ();

    spi_crypto_frame_ctrl #(.nk(NK), .nb(NB), .core_lat(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    spi_crypto_frame_ctrl #(.nk(NK), .nb(NB), .core_lat(LAT1)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    // Core stand-in: known FIPS-197 pair in both directions, otherwise a keyed scramble.
    function automatic logic [127:0] core_fn(input logic [127:0] m, input logic [127:0] k, input logic md);
        if (k == FK && md && m == PT)  return CT;
        if (k == FK && !md && m == CT) return PT;
        return md ? (m ^ k) : ({m[63:0], m[127:64]} ^ ~k);
    endfunction

    assign bus0.cs = cs;
    assign bus0.mosi = mosi;
    assign bus3.cs = cs;
    assign bus3.mosi = mosi;
    assign bus0.core_out = core_fn(bus0.core_msg, bus0.core_key, bus0.core_mode);
    assign bus3.core_out = core_fn(bus3.core_msg, bus3.core_key, bus3.core_mode);

    logic [1:0]   miso_o, done_o, err_o, busy_o, kv_o, mode_o;
    logic [127:0] key_o [2];
    logic [127:0] msg_o [2];

    assign miso_o = {bus3.miso, bus0.miso};
    assign done_o = {bus3.data_done, bus0.data_done};
    assign err_o  = {bus3.err, bus0.err};
    assign busy_o = {bus3.busy, bus0.busy};
    assign kv_o   = {bus3.key_valid, bus0.key_valid};
    assign mode_o = {bus3.core_mode, bus0.core_mode};
    assign key_o[0] = bus0.core_key;
    assign key_o[1] = bus3.core_key;
    assign msg_o[0] = bus0.core_msg;
    assign msg_o[1] = bus3.core_msg;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_miso"}, miso_o, 2'b00);
        chk({tag, "_done"}, done_o, 2'b00);
        chk({tag, "_busy"}, busy_o, 2'b00);
        chk({tag, "_err"},  err_o,  2'b00);
        chk({tag, "_kv"},   kv_o,   2'b00);
        chk({tag, "_mode"}, mode_o, 2'b00);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_key"}, key_o[d], '0);
            chk({tag, "_msg"}, msg_o[d], '0);
        end
    endtask

    // One frame: header, optional key, block, then enough low-cs cycles to drain the result.
    // abort_at >= 0 raises cs before that edge; rst_at >= 0 pulses rst just after that edge.
    task automatic frame(input logic [7:0] hdr, input logic [127:0] key, input logic [127:0] msg,
                         input int abort_at, input int gap, input int rst_at);
        logic [263:0] bits;
        logic [127:0] stream [2];
        logic [127:0] res;
        logic         kl, md, key_ok, exp_err;
        int           total, e, ncyc, last;
        int           sc [2];
        int           done_n [2];
        int           done_c [2];
        int           err_n [2];
        int           err_c [2];
        int           bad [2];
        kl      = hdr[6];
        md      = hdr[7];
        bits    = kl ? {hdr, key, msg} : {hdr, msg, 128'b0};
        total   = kl ? 264 : 136;
        e       = total - 1;
        ncyc    = total + LAT1 + 1 + 128 + 2;
        last    = (abort_at >= 0) ? abort_at - 1 : ncyc - 1;
        key_ok  = kl ? (last >= 135) : mkv;
        exp_err = !kl && !mkv && (last >= 7);
        res     = core_fn(msg, kl ? key : mk, md);
        for (int d = 0; d < 2; d++) begin
            stream[d] = '0; sc[d] = 0; done_n[d] = 0; done_c[d] = -1;
            err_n[d] = 0; err_c[d] = -1; bad[d] = 0;
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cs   = (abort_at >= 0 && c >= abort_at);
            mosi = (c < total) ? bits[263-c] : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (c == 0) chk("busy_frame_start", busy_o, 2'b11);
            if (abort_at >= 0 && c == abort_at) chk("abort_to_idle", busy_o, 2'b00);
            if (c == rst_at) begin
                #1 rst = 1'b1;
                #1 chk_reset_state("rst_async");
                rst = 1'b0;
                mk  = '0;
                mkv = 1'b0;
                @(negedge clk);
                cs = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            for (int d = 0; d < 2; d++) begin
                int cap;
                cap = e + ((d == 0) ? 0 : LAT1) + 1;
                if (done_o[d]) begin done_n[d]++; done_c[d] = c; end
                if (err_o[d])  begin err_n[d]++;  err_c[d]  = c; end
                if (key_ok && c >= cap && c <= cap + 127 && c <= last) begin
                    stream[d] = {stream[d][126:0], miso_o[d]};
                    sc[d]++;
                end else if (miso_o[d]) begin
                    bad[d]++;
                end
            end
        end
        if (kl && last >= 135) begin
            mk  = key;
            mkv = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            int   cap;
            logic out_exp;
            cap     = e + ((d == 0) ? 0 : LAT1) + 1;
            out_exp = key_ok && (cap <= last);
            chk("done_count", done_n[d], out_exp ? 1 : 0);
            if (out_exp) begin
                chk("done_cycle", done_c[d], cap);
                chk("miso_stream", stream[d], res >> (128 - sc[d]));
            end
            if (key_ok && e <= last) begin
                chk("core_mode", mode_o[d], md);
                chk("core_msg", msg_o[d], msg);
            end
            chk("miso_quiet", bad[d], 0);
            chk("err_count", err_n[d], exp_err ? 1 : 0);
            if (exp_err) chk("err_cycle", err_c[d], 7);
            chk("key_valid", kv_o[d], mkv);
            chk("core_key", key_o[d], mk);
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            cs = 1'b1;
            @(posedge clk);
            #1;
            if (g == 0) chk("busy_gap", busy_o, 2'b00);
        end
    endtask

    initial begin
        logic [7:0]   hdr;
        logic [127:0] key, msg;
        logic         kl;
        int           tot, ab;
        rst  = 1'b1;
        cs   = 1'b1;
        mosi = 1'b0;
        mk   = '0;
        mkv  = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        frame(8'h80, '0, PT, -1, 1, -1);
        frame(8'hC0, FK, PT, -1, 1, -1);
        frame(8'h00, '0, CT, -1, 1, -1);
        frame(8'hC0, {4{$urandom}}, PT, 108, 2, -1);
        frame(8'h80, '0, PT, -1, 1, -1);

        for (int i = 0; i < 12; i++) begin
            kl  = ($urandom_range(0, 2) == 0);
            hdr = {1'($urandom_range(0, 1)), kl, 6'($urandom)};
            key = {$urandom, $urandom, $urandom, $urandom};
            msg = {$urandom, $urandom, $urandom, $urandom};
            tot = kl ? 264 : 136;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, tot + LAT1 + 61)) : -1;
            frame(hdr, key, msg, ab, int'($urandom_range(1, 3)), -1);
        end

        frame(8'h80, '0, {4{$urandom}}, -1, 1, 135 + LAT1 + 1 + 20);
        frame(8'h00, '0, PT, -1, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
